seg_letter_decoder: RTL and testbench

- Inverse of the letter-to-7-segment encoder: samples an active-low 7-segment pattern bus (segment order 6..0 = g..a), waits until it is stable, and decodes it back to the 5-bit letter code.
- Decoded codes are buffered in a small FIFO with a valid/ready output handshake.
- Used for display loop-back checking and for reading patterns driven by another board.

---
 rtl/seg_letter_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg_letter_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_letter_decoder.sv
// seg_letter_decoder
//   Turns an active-low 7-segment pattern back into a 5-bit letter code.
//   The pattern is synchronised and must be held steady before it is accepted.
//   Each accepted code is pushed into a small first-word-fall-through FIFO,
//   which the consumer drains with a valid/ready handshake.
//
// Optional build macro: SEG_DIGIT_DECODE_EN
//   When defined, the standard digit patterns 0-9 also decode, to codes 16-25.
//   When undefined, those digit patterns raise err_pulse instead.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   seg_in     active-low segment pattern (bit 6..0 = g..a), asynchronous to clk
//   out_code   letter code at the FIFO head (0 when the FIFO is empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head when high together with out_valid
//   err_pulse  one-cycle pulse for a stable, unrecognised, non-blank pattern
//   overflow   sticky flag: a decoded code was dropped because the FIFO was full
//   fill       current FIFO occupancy
module seg_letter_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               seg_in,
  output logic [4:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_pulse,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [6:0]    BLANK   = 7'b1111111;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [PW-1:0] FULL_LV = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, HOLD} state_t;

  logic [6:0]    sync1, sample, prev_sample;
  logic          changed;
  logic [CW-1:0] cnt, cnt_next;
  state_t        state, state_next;
  logic          hit;
  logic [4:0]    code;
  logic          push, pop, full, do_push;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    mem [DEPTH];

  // Two-flop synchroniser, plus a copy of the previous sample for change
  // detection. All three reset to blank, so a pattern that is held through
  // reset is seen as a fresh change afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= BLANK;
      sample      <= BLANK;
      prev_sample <= BLANK;
    end else begin
      sync1       <= seg_in;
      sample      <= sync1;
      prev_sample <= sample;
    end
  end

  assign changed = (sample != prev_sample);

  // Stability counter: it reloads to 1 on any change and otherwise
  // saturates at STABLE_CYCLES.
  always_comb begin
    cnt_next = cnt;
    if (changed)
      cnt_next = CW'(1);
    else if (cnt != CNT_MAX)
      cnt_next = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic. COUNT moves to FIRE on the same edge at which the
  // counter reaches its limit, so FIRE lines up with the last stable sample.
  // HOLD stops a held pattern from firing a second time.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (changed) state_next = COUNT;
      COUNT: if (!changed && (cnt_next == CNT_MAX)) state_next = FIRE;
      FIRE:  state_next = HOLD;
      HOLD:  if (changed) state_next = COUNT;
      default: state_next = IDLE;
    endcase
  end

  // Pattern decode. Letters are listed first, so they win over any digit
  // pattern that happens to overlap.
  always_comb begin
    hit  = 1'b0;
    code = 5'd0;
    case (sample)
      7'b0001000: begin hit = 1'b1; code = 5'd0;  end
      7'b0000011: begin hit = 1'b1; code = 5'd1;  end
      7'b1000110: begin hit = 1'b1; code = 5'd2;  end
      7'b0100001: begin hit = 1'b1; code = 5'd3;  end
      7'b0000110: begin hit = 1'b1; code = 5'd4;  end
      7'b0001110: begin hit = 1'b1; code = 5'd5;  end
      7'b0010000: begin hit = 1'b1; code = 5'd6;  end
      7'b0001011: begin hit = 1'b1; code = 5'd7;  end
      7'b1110000: begin hit = 1'b1; code = 5'd8;  end
      7'b1110001: begin hit = 1'b1; code = 5'd9;  end
      7'b0001111: begin hit = 1'b1; code = 5'd10; end
`ifdef SEG_DIGIT_DECODE_EN
      7'b1000000: begin hit = 1'b1; code = 5'd16; end
      7'b1111001: begin hit = 1'b1; code = 5'd17; end
      7'b0100100: begin hit = 1'b1; code = 5'd18; end
      7'b0110000: begin hit = 1'b1; code = 5'd19; end
      7'b0011001: begin hit = 1'b1; code = 5'd20; end
      7'b0010010: begin hit = 1'b1; code = 5'd21; end
      7'b0000010: begin hit = 1'b1; code = 5'd22; end
      7'b1111000: begin hit = 1'b1; code = 5'd23; end
      7'b0000000: begin hit = 1'b1; code = 5'd24; end
      7'b0011000: begin hit = 1'b1; code = 5'd25; end
`else
`endif
      default: begin hit = 1'b0; code = 5'd0; end
    endcase
  end

  // Output logic. A blank pattern in FIRE is silently ignored.
  always_comb begin
    push      = 1'b0;
    err_pulse = 1'b0;
    if (state == FIRE) begin
      push      = hit;
      err_pulse = !hit && (sample != BLANK);
    end
  end

  // FIFO pointers carry one extra wrap bit, so full and empty can be told
  // apart. When the FIFO is full, a push is still accepted if a pop happens
  // in the same cycle.
  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == FULL_LV);
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign do_push   = push && (!full || pop);
  assign out_code  = out_valid ? mem[rd_ptr[AW-1:0]] : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Storage is not reset. out_code is forced to 0 while the FIFO is empty,
  // so stale entries never reach the output.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= code;
  end

endmodule

// File: tb/tb_seg_letter_decoder.sv
// Self-checking bench for seg_letter_decoder (STABLE_CYCLES=4, DEPTH=4).
module tb_seg_letter_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] P_A   = 7'b0001000;
  localparam logic [6:0] P_B   = 7'b0000011;
  localparam logic [6:0] P_C   = 7'b1000110;
  localparam logic [6:0] P_D   = 7'b0100001;
  localparam logic [6:0] P_E   = 7'b0000110;
  localparam logic [6:0] P_K   = 7'b0001111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = BLANK;
  logic [4:0] out_code;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_pulse;
  logic       overflow;
  logic [2:0] fill;

  int checks = 0;
  int errors = 0;
  int err_count = 0;
  int popped[$];

  typedef struct {
    string      name;
    logic [6:0] pat;
    int         exp_valid;
    int         exp_code;
    int         exp_err;
  } vec_t;

  vec_t vecs[9];

  seg_letter_decoder #(.STABLE_CYCLES(STABLE), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .overflow  (overflow),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  // One clock. Records the head if it is popped at this edge, then samples
  // err_pulse 1 time unit after the edge.
  task automatic tick();
    if (out_valid && out_ready)
      popped.push_back(int'(out_code));
    @(posedge clk);
    #1;
    if (err_pulse)
      err_count++;
  endtask

  task automatic applyStimulus(input logic [6:0] pat, input int cycles);
    seg_in = pat;
    for (int i = 0; i < cycles; i++)
      tick();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    err_count = 0;
  endtask

  initial begin
    vecs[0] = '{"vec_A",     7'b0001000, 1, 0,  0};
    vecs[1] = '{"vec_E",     7'b0000110, 1, 4,  0};
    vecs[2] = '{"vec_J",     7'b1110001, 1, 9,  0};
    vecs[3] = '{"vec_k",     7'b0001111, 1, 10, 0};
    vecs[4] = '{"vec_bad",   7'b1010101, 0, 0,  1};
    vecs[5] = '{"vec_g",     7'b0010000, 1, 6,  0};
    vecs[6] = '{"vec_blank", 7'b1111111, 0, 0,  0};
`ifdef SEG_DIGIT_DECODE_EN
    vecs[7] = '{"vec_dig2",  7'b0100100, 1, 18, 0};
    vecs[8] = '{"vec_dig8",  7'b0000000, 1, 24, 0};
`else
    vecs[7] = '{"vec_dig2",  7'b0100100, 0, 0,  1};
    vecs[8] = '{"vec_dig8",  7'b0000000, 0, 0,  1};
`endif

    // Reset state
    @(posedge clk);
    #1;
    doReset();
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_fill", int'(fill), 0);
    checkOutput("rst_code", int'(out_code), 0);
    checkOutput("rst_overflow", int'(overflow), 0);

    // Single letter held: latency and exactly one entry
    out_ready = 1'b0;
    applyStimulus(P_A, STABLE + 2);
    checkOutput("lat_not_yet", int'(out_valid), 0);
    tick();
    checkOutput("lat_valid", int'(out_valid), 1);
    checkOutput("lat_code", int'(out_code), 0);
    applyStimulus(P_A, 20 - (STABLE + 3));
    checkOutput("hold_fill", int'(fill), 1);
    checkOutput("hold_err", err_count, 0);

    // Glitching input never fires; the steady value fires once
    doReset();
    for (int i = 0; i < 10; i++)
      applyStimulus((i % 2 == 0) ? P_B : P_C, 2);
    checkOutput("glitch_fill", int'(fill), 0);
    applyStimulus(P_C, 12);
    checkOutput("glitch_fill_after", int'(fill), 1);
    checkOutput("glitch_code", int'(out_code), 2);
    checkOutput("glitch_err", err_count, 0);

    // A, blank, A, blank, k drained continuously
    doReset();
    popped.delete();
    out_ready = 1'b1;
    applyStimulus(P_A, 8);
    applyStimulus(BLANK, 8);
    applyStimulus(P_A, 8);
    applyStimulus(BLANK, 8);
    applyStimulus(P_K, 12);
    checkOutput("seq_count", popped.size(), 3);
    if (popped.size() == 3) begin
      checkOutput("seq_0", popped[0], 0);
      checkOutput("seq_1", popped[1], 0);
      checkOutput("seq_2", popped[2], 10);
    end
    checkOutput("seq_err", err_count, 0);
    out_ready = 1'b0;

    // Table-driven decode vectors, each separated by blank
    doReset();
    for (int v = 0; v < 9; v++) begin
      applyStimulus(BLANK, 8);
      err_count = 0;
      applyStimulus(vecs[v].pat, 10);
      checkOutput({vecs[v].name, "_err"}, err_count, vecs[v].exp_err);
      checkOutput({vecs[v].name, "_valid"}, int'(out_valid), vecs[v].exp_valid);
      checkOutput({vecs[v].name, "_fill"}, int'(fill), vecs[v].exp_valid);
      checkOutput({vecs[v].name, "_code"}, int'(out_code), vecs[v].exp_code);
      if (out_valid) begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end

    // Overflow: five letters into a four-entry FIFO
    doReset();
    applyStimulus(P_A, 8);
    applyStimulus(P_B, 8);
    applyStimulus(P_C, 8);
    applyStimulus(P_D, 8);
    checkOutput("ovf_fill4", int'(fill), 4);
    checkOutput("ovf_before", int'(overflow), 0);
    applyStimulus(P_E, 8);
    checkOutput("ovf_fill5", int'(fill), 4);
    checkOutput("ovf_set", int'(overflow), 1);
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      tick();
    out_ready = 1'b0;
    checkOutput("drain_count", popped.size(), 4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      checkOutput($sformatf("drain_%0d", i), popped[i], i);
    checkOutput("drain_empty", int'(out_valid), 0);
    checkOutput("ovf_sticky", int'(overflow), 1);

    // Reset with three entries queued and the FSM counting
    applyStimulus(P_A, 8);
    applyStimulus(P_B, 8);
    applyStimulus(P_C, 8);
    checkOutput("mid_fill3", int'(fill), 3);
    applyStimulus(P_D, 4);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_fill", int'(fill), 0);
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_ovf", int'(overflow), 0);
    tick();
    reset = 1'b0;
    applyStimulus(P_D, 10);
    checkOutput("redetect_fill", int'(fill), 1);
    checkOutput("redetect_code", int'(out_code), 3);
    applyStimulus(P_D, 20);
    checkOutput("redetect_once", int'(fill), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
